// File: rtl/hp_alarm_logger.sv
// Alarm event logger: synchronizes two asynchronous alarm lines, timestamps their
// rising edges into a FIFO and exposes it through a 16-byte Wishbone register window.
module hp_alarm_logger #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100,
    parameter int          DEPTH        = 16,
    parameter int          TS_WIDTH     = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    input  logic        alarm_p,
    input  logic        alarm_n,
    output logic        irq
);
    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam int            EW       = TS_WIDTH + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_TIME   = 2'd3;

    logic                p_meta_q, p_sync_q, p_prev_q;
    logic                n_meta_q, n_sync_q, n_prev_q;
    logic                p_ev, n_ev, ev_any;
    logic [TS_WIDTH-1:0] ts_q;

    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          ovf_q, ovf_d;
    logic                en_q, en_d;
    logic                ack_q, irq_q;
    logic [31:0]         rdata_q, rd_val;

    logic                empty, full, push, pop, ovf_inc;
    logic                in_win, req, rd_req, wr_ctrl, flush, ovf_clr;
    logic [1:0]          reg_sel;
    logic [EW-1:0]       head;
    logic                unused_bits;

    // Two-flop synchronizer per line; the third flop only remembers the last synced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            {p_meta_q, p_sync_q, p_prev_q} <= '0;
            {n_meta_q, n_sync_q, n_prev_q} <= '0;
        end else begin
            p_meta_q <= alarm_p;
            p_sync_q <= p_meta_q;
            p_prev_q <= p_sync_q;
            n_meta_q <= alarm_n;
            n_sync_q <= n_meta_q;
            n_prev_q <= n_sync_q;
        end
    end

    assign p_ev   = p_sync_q & ~p_prev_q;
    assign n_ev   = n_sync_q & ~n_prev_q;
    assign ev_any = en_q & (p_ev | n_ev);

    assign in_win  = (i_wb_addr[31:4] == BASE_ADDRESS[31:4]);
    assign req     = i_wb_cyc & i_wb_stb & in_win;
    assign reg_sel = i_wb_addr[3:2];
    assign rd_req  = req & ~i_wb_we;
    assign wr_ctrl = req & i_wb_we & (reg_sel == REG_CTRL);
    assign flush   = wr_ctrl & i_wb_data[1];
    assign ovf_clr = wr_ctrl & i_wb_data[2];

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign pop     = rd_req & (reg_sel == REG_DATA) & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the event.
    assign push    = ev_any & ~flush & (~full | pop);
    assign ovf_inc = ev_any & ~flush & full & ~pop;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_STATUS: rd_val = {8'd0, ovf_q, 3'd0, 9'(cnt_q), 2'd0, full, empty};
            REG_DATA:   rd_val = empty ? 32'd0 : {head[EW-1:EW-2], 30'(head[TS_WIDTH-1:0])};
            REG_CTRL:   rd_val = {31'd0, en_q};
            REG_TIME:   rd_val = 32'(ts_q);
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        en_d     = en_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push & ~pop)      cnt_d = cnt_q + CW'(1);
            else if (pop & ~push) cnt_d = cnt_q - CW'(1);
        end
        if (ovf_clr)                          ovf_d = '0;
        else if (ovf_inc && ovf_q != 8'hFF)   ovf_d = ovf_q + 8'd1;
        if (wr_ctrl) en_d = i_wb_data[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= '0;
            en_q     <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            ts_q     <= ts_q + TS_WIDTH'(1);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            en_q     <= en_d;
            ack_q    <= req;
            rdata_q  <= rd_req ? rd_val : 32'd0;
            irq_q    <= en_q & ~empty;
        end
    end

    // Storage is left unreset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {n_ev, p_ev, ts_q};
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;
    assign irq        = irq_q;

    assign unused_bits = ^{i_wb_data[31:3], i_wb_addr[1:0]};
endmodule

// File: tb/tb_hp_alarm_logger.sv
// Randomized bench for hp_alarm_logger against a queue-based reference model.
module tb_hp_alarm_logger;
    localparam int          DEPTH = 16;
    localparam int          TSW   = 8;
    localparam logic [31:0] BASE  = 32'h3000_0100;

    logic        clk, reset;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_wdata;
    logic        o_wb_ack, o_wb_stall, irq;
    logic [31:0] o_wb_data;
    logic        alarm_p, alarm_n;

    int n_chk = 0;
    int n_fail = 0;

    hp_alarm_logger #(.BASE_ADDRESS(BASE), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk(clk), .reset(reset),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_wdata),
        .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
        .alarm_p(alarm_p), .alarm_n(alarm_n), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of entries, counters as plain ints, alarm history as raw samples.
    logic [31:0] mq[$];
    int          m_ovf, m_ts;
    bit          m_en, started;
    bit   [2:0]  hp, hn;
    logic        e_ack, e_irq;
    logic [31:0] e_data;

    task automatic model_step();
        bit          req, rd, pop, ctrl, flush, clr, evp, evn, ev;
        int          sel;
        longint      a;
        logic [31:0] rv, st;
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_en = 0; m_ts = 0; hp = '0; hn = '0;
            e_ack = 0; e_data = 0; e_irq = 0;
            return;
        end
        a   = longint'(wb_addr);
        req = wb_cyc && wb_stb && a >= longint'(BASE) && a < longint'(BASE) + 16;
        sel = req ? int'((a - longint'(BASE)) / 4) : 0;
        rd  = req && !wb_we;
        st  = (32'(m_ovf) << 16) | (32'(mq.size()) << 4)
            | ((mq.size() == DEPTH) ? 32'd2 : 32'd0) | ((mq.size() == 0) ? 32'd1 : 32'd0);
        rv = 0;
        if (rd) begin
            case (sel)
                0: rv = st;
                1: rv = (mq.size() > 0) ? mq[0] : 32'd0;
                2: rv = {31'd0, m_en};
                3: rv = 32'(m_ts);
                default: rv = 0;
            endcase
        end
        e_irq = m_en && mq.size() > 0;
        pop   = rd && sel == 1 && mq.size() > 0;
        ctrl  = req && wb_we && sel == 2;
        flush = ctrl && wb_wdata[1];
        clr   = ctrl && wb_wdata[2];
        // An input edge sampled at clock N-2 (0 at N-3) is logged at clock N.
        evp = hp[1] && !hp[2];
        evn = hn[1] && !hn[2];
        ev  = m_en && (evp || evn);
        if (pop) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (ev) begin
            if (mq.size() < DEPTH) mq.push_back({evn, evp, 30'(m_ts)});
            else if (m_ovf < 255) m_ovf++;
        end
        if (clr)  m_ovf = 0;
        if (ctrl) m_en = wb_wdata[0];
        hp = {hp[1:0], alarm_p};
        hn = {hn[1:0], alarm_n};
        m_ts  = (m_ts + 1) % (1 << TSW);
        e_ack = req;
        e_data = rv;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            started = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("ack",   {31'd0, o_wb_ack}, {31'd0, e_ack});
                chk("rdata", o_wb_data, e_data);
                chk("irq",   {31'd0, irq}, {31'd0, e_irq});
                chk("stall", {31'd0, o_wb_stall}, 32'd0);
            end
        end
    end

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ack);
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_addr = addr; wb_wdata = wd;
        @(negedge clk);
        rd = o_wb_data; ack = o_wb_ack;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    // ets: the timestamp the event must carry (counter two clocks after the raise).
    task automatic pulse(input logic p, input logic n, input int hi, output int ets);
        @(negedge clk);
        alarm_p = p; alarm_n = n;
        ets = (m_ts + 2) % (1 << TSW);
        repeat (hi) @(negedge clk);
        alarm_p = 0; alarm_n = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, prev, wd;
        logic        ack;
        logic [1:0]  s;
        int          t, d;
        bit          wrapped;

        reset = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = 0; wb_wdata = 0;
        alarm_p = 0; alarm_n = 0;
        repeat (3) @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = BASE + 8; wb_wdata = 1;
        @(negedge clk);
        chk("abort_ack", {31'd0, o_wb_ack}, 32'd0);
        reset = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0;
        bus(0, BASE + 0, 0, rd, ack); chk("rst_status", rd, 32'h1);
        bus(0, BASE + 8, 0, rd, ack); chk("rst_ctrl", rd, 32'h0);

        // single positive event
        bus(1, BASE + 8, 1, rd, ack);
        pulse(1, 0, 5, t);
        bus(0, BASE + 0, 0, rd, ack); chk("s1_status", rd, 32'h10);
        chk("s1_irq", {31'd0, irq}, 32'd1);
        bus(0, BASE + 4, 0, rd, ack); chk("s1_data", rd, {2'b01, 30'(t)});

        // simultaneous p/n
        pulse(1, 1, 3, t);
        bus(0, BASE + 4, 0, rd, ack); chk("s2_data", rd, {2'b11, 30'(t)});
        bus(0, BASE + 4, 0, rd, ack); chk("s2_empty_data", rd, 32'd0);
        bus(0, BASE + 0, 0, rd, ack); chk("s2_status", rd, 32'h1);
        repeat (2) @(negedge clk);
        chk("s2_irq", {31'd0, irq}, 32'd0);

        // overflow by one
        for (int i = 0; i < 17; i++) begin
            s = 2'($urandom_range(1, 3));
            pulse(s[0], s[1], $urandom_range(1, 3), t);
        end
        bus(0, BASE + 0, 0, rd, ack); chk("s3_status", rd, 32'h10102);

        // event lands on the same clock as a DATA read while full
        @(negedge clk); alarm_p = 1; t = (m_ts + 2) % (1 << TSW);
        @(negedge clk);
        bus(0, BASE + 4, 0, rd, ack);
        alarm_p = 0; repeat (4) @(negedge clk);
        bus(0, BASE + 0, 0, rd, ack); chk("s4_status", rd, 32'h10102);
        for (int i = 0; i < 16; i++) bus(0, BASE + 4, 0, rd, ack);
        chk("s4_last", rd, {2'b01, 30'(t)});
        bus(0, BASE + 0, 0, rd, ack); chk("s4_drained", rd, 32'h10001);

        // flush coincident with push
        pulse(1, 0, 2, t); pulse(0, 1, 2, t);
        @(negedge clk); alarm_p = 1;
        @(negedge clk);
        bus(1, BASE + 8, 3, rd, ack);
        alarm_p = 0; repeat (4) @(negedge clk);
        bus(0, BASE + 0, 0, rd, ack); chk("flush_push", rd, 32'h10001);

        // OVF clear coincident with overflow increment
        for (int i = 0; i < 16; i++) pulse(1, 0, 1, t);
        bus(0, BASE + 0, 0, rd, ack); chk("refill", rd, 32'h10102);
        @(negedge clk); alarm_n = 1;
        @(negedge clk);
        bus(1, BASE + 8, 5, rd, ack);
        alarm_n = 0; repeat (4) @(negedge clk);
        bus(0, BASE + 0, 0, rd, ack); chk("clr_inc", rd, 32'h00102);
        bus(0, BASE + 8, 0, rd, ack); chk("ctrl_rb", rd, 32'h1);
        bus(1, BASE + 8, 6, rd, ack);
        bus(0, BASE + 0, 0, rd, ack); chk("flush_pending", rd, 32'h1);
        bus(0, BASE + 8, 0, rd, ack); chk("ctrl_off", rd, 32'h0);

        // disabled: events ignored
        for (int i = 0; i < 3; i++) pulse(1, 1, 2, t);
        bus(0, BASE + 0, 0, rd, ack); chk("en0_status", rd, 32'h1);
        chk("en0_irq", {31'd0, irq}, 32'd0);

        // randomized traffic
        bus(1, BASE + 8, 1, rd, ack);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 11))
                0, 1, 2: begin
                    s = 2'($urandom_range(1, 3));
                    pulse(s[0], s[1], $urandom_range(1, 3), t);
                end
                3, 4, 5: bus(0, BASE + 4, 0, rd, ack);
                6: bus(0, BASE + 0, 0, rd, ack);
                7: bus(0, BASE + 12, 0, rd, ack);
                8: begin
                    wd = 0;
                    wd[0] = ($urandom_range(0, 3) != 0);
                    wd[1] = ($urandom_range(0, 7) == 0);
                    wd[2] = ($urandom_range(0, 3) == 0);
                    bus(1, BASE + 8, wd, rd, ack);
                end
                9: begin
                    wd = ($urandom_range(0, 1) != 0) ? BASE + 16 + 4 * $urandom_range(0, 3)
                                                     : BASE - 4 * $urandom_range(1, 4);
                    bus(1'($urandom_range(0, 1)), wd, 32'h7, rd, ack);
                    chk("oow_rand_ack", {31'd0, ack}, 32'd0);
                end
                10: begin
                    d = $urandom_range(0, 2);
                    bus(1, BASE + ((d == 2) ? 12 : 4 * d), $urandom, rd, ack);
                end
                default: begin
                    s = 2'($urandom_range(1, 3));
                    @(negedge clk); alarm_p = s[0]; alarm_n = s[1];
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    if ($urandom_range(0, 1) != 0) bus(0, BASE + 4, 0, rd, ack);
                    else bus(1, BASE + 8, {29'd0, 3'($urandom_range(0, 7)) | 3'd1}, rd, ack);
                    alarm_p = 0; alarm_n = 0;
                    repeat (4) @(negedge clk);
                end
            endcase
        end

        // timestamp wrap
        bus(1, BASE + 8, 3, rd, ack);
        for (int i = 0; i < 600 && m_ts != 250; i++) @(negedge clk);
        chk("wrap_reach", 32'(m_ts), 32'd250);
        wrapped = 0; prev = 0;
        for (int i = 0; i < 8; i++) begin
            bus(0, BASE + 12, 0, rd, ack);
            if (i > 0 && rd < prev) wrapped = 1;
            prev = rd;
        end
        chk("time_wrap", {31'd0, wrapped}, 32'd1);
        pulse(1, 0, 2, t);
        bus(0, BASE + 4, 0, rd, ack);
        chk("wrap_ts", rd, {2'b01, 30'(t)});
        chk("wrap_small", {31'd0, rd[29:0] < 30'd32}, 32'd1);

        // out-of-window accesses
        bus(0, BASE + 16, 0, rd, ack);
        chk("oow_hi_ack", {31'd0, ack}, 32'd0);
        chk("oow_hi_data", rd, 32'd0);
        bus(1, BASE - 4, 32'h6, rd, ack);
        chk("oow_lo_ack", {31'd0, ack}, 32'd0);
        bus(0, BASE + 8, 0, rd, ack); chk("oow_ctrl_kept", rd, 32'h1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
